// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam int          IMEM_AW  = 10;

  typedef enum logic [1:0] {
    PC_SEQ      = 2'd0,
    PC_HOLD     = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory read port: word address out, combinational instruction back.
interface if_stage_if;
  import if_stage_pkg::*;

  logic [IMEM_AW-1:0] im_addr;
  logic [31:0]        im_dout;

  modport master (output im_addr, input im_dout);
  modport slave  (input im_addr, output im_dout);
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: clear wins over enable, so a redirect or flush
// always leaves a bubble even while the hazard unit is stalling.
module if_stage_if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP = if_stage_pkg::NOP
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   clr,
  input  if_id_t d,
  output if_id_t q
);

  localparam if_id_t BUBBLE = '{pc: 32'h0, pc4: 32'h0, instr: NOP, valid: 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= BUBBLE;
    end else if (clr) begin
      q <= BUBBLE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID
// register feeding decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = if_stage_pkg::RESET_PC,
  parameter logic [31:0] NOP      = if_stage_pkg::NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  if_stage_if.master  imem,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        misalign
);

  pc_sel_e     pc_sel;
  logic [31:0] pc_plus4;
  if_id_t      if_id_d;
  if_id_t      if_id_q;

  assign pc_plus4     = pc + PC_STEP;
  assign imem.im_addr = pc[IMEM_AW+1:2];

  // A resolved redirect outranks the stall so the wrong-path fetch never survives.
  always_comb begin
    pc_sel = PC_SEQ;
    if (redirect_valid) begin
      pc_sel = PC_REDIRECT;
    end else if (stall) begin
      pc_sel = PC_HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      misalign <= redirect_valid && (redirect_target[1:0] != 2'b00);
      case (pc_sel)
        PC_REDIRECT: pc <= {redirect_target[31:2], 2'b00};
        PC_HOLD:     pc <= pc;
        default:     pc <= pc_plus4;
      endcase
    end
  end

  assign if_id_d = '{pc: pc, pc4: pc_plus4, instr: imem.im_dout, valid: 1'b1};

  if_stage_if_id_reg #(
    .NOP (NOP)
  ) u_if_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!stall),
    .clr   (flush || redirect_valid),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign if_id_pc    = if_id_q.pc;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_instr = if_id_q.instr;
  assign if_id_valid = if_id_q.valid;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core.
- Holds the program counter and drives the word address of the 4 KB instruction memory (1024 words, combinational read).
- Captures the returned instruction into the IF/ID pipeline register.
- Handles load-use stalls, branch/jump redirects from later stages, and flushes, delivering {pc, pc+4, instr, valid} to the decode stage.

Parameters:
- RESET_PC, 32'h0000_3000: PC value after reset. Its bits [11:2] select IMem word 0.
- NOP, 32'h0000_0000: instruction word inserted as a bubble (sll $0,$0,0).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit: hold PC and IF/ID contents.
- flush  in  1  kill the IF/ID contents (insert bubble). Does not change the PC.
- redirect_valid  in  1  branch taken / j / jal / jr resolved this cycle.
- redirect_target  in  32  new PC for the redirect.
- im_addr  out  10  word address [11:2] to instruction memory.
- im_dout  in  32  instruction word from memory (same-cycle combinational).
- pc  out  32  current fetch PC.
- if_id_pc  out  32  PC of the instruction held in IF/ID.
- if_id_pc4  out  32  if_id_pc + 4, for jal/branch offset.
- if_id_instr  out  32  instruction held in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.
- misalign  out  1  registered one-cycle pulse: a redirect target had bits[1:0] != 0.

Behaviour:
- Reset, asynchronous on rst_n low:
  - pc = RESET_PC, if_id_pc = 0, if_id_pc4 = 0, if_id_instr = NOP, if_id_valid = 0, misalign = 0.
  - Reset may assert mid-operation; all state returns to the values above immediately.
- im_addr = pc[11:2], purely combinational. The instruction fetched at PC P appears on if_id_instr at the next rising edge (1-cycle latency).
- Each rising edge, evaluate in priority order (first match wins for the PC):
  1. redirect_valid:
     - pc <= {redirect_target[31:2], 2'b00}.
     - IF/ID <= bubble (instr = NOP, valid = 0, pc/pc4 = 0).
     - misalign <= (redirect_target[1:0] != 0).
     - Redirect overrides stall: the wrong-path fetch is discarded even while stalled.
  2. stall:
     - pc and every IF/ID field hold.
     - If flush is also asserted, IF/ID still becomes a bubble while pc holds.
  3. Otherwise:
     - pc <= pc + 4.
     - If flush: IF/ID <= bubble.
     - Else: if_id_instr <= im_dout, if_id_pc <= pc, if_id_pc4 <= pc + 4, if_id_valid <= 1.
- misalign is 0 on every edge without a misaligned redirect. It is a pulse, not sticky.
- Arithmetic:
  - PC increment is 32-bit modulo 2^32; FFFF_FFFC + 4 wraps to 0000_0000 with no flag.
  - im_addr naturally wraps within the 4 KB window: pc 0x0000_3FFC -> 0x3FF, next pc 0x0000_4000 -> im_addr 0x000.
  - Bits above [11] are not range-checked.
- Bubble encoding: instr = NOP and valid = 0 always together. Decode treats valid = 0 as no register writes and no memory side-effects.
- Consecutive redirects on back-to-back cycles: each one applies; the last one wins the PC.
- Stall held for N cycles: the IF/ID instruction is presented unchanged for N+1 cycles and no instruction is skipped.

Decomposition:
- Shared package: RESET_PC, NOP, PC_STEP = 4, IMEM_AW = 10.
- Optional sub-module if_id_reg: the IF/ID pipeline register with enable (= !stall) and synchronous clear (flush | redirect).
- PC register and next-PC selection stay in if_stage.

Test Plan:
- Reset release, memory words 0..3 = 0x20080001, 0x20090002, 0x01095020, 0xAC0A0000, no stall/redirect:
  - im_addr = 0,1,2,3 on consecutive cycles.
  - if_id_instr follows one cycle later with if_id_pc = 0x3000,0x3004,0x3008,0x300C.
  - if_id_valid rises on the first edge after reset.
- Stall for 2 cycles while if_id_pc = 0x3004:
  - pc stays 0x3008 and if_id_instr stays 0x20090002 for 3 cycles.
  - Then 0x01095020 appears with if_id_pc = 0x3008.
- redirect_valid with target 0x3020 at pc = 0x300C:
  - Next cycle pc = 0x3020, im_addr = 8, IF/ID is a bubble (NOP, valid = 0).
  - Following cycle if_id_pc = 0x3020.
- Redirect and stall asserted in the same cycle, target 0x3040:
  - pc = 0x3040 and IF/ID is a bubble; the stall is ignored for the PC.
- Redirect target 0x3022:
  - pc = 0x3020 and misalign = 1 for exactly one cycle.
- Assert rst_n low asynchronously mid-cycle while pc = 0x3010:
  - pc = 0x3000, if_id_valid = 0, if_id_instr = NOP before the next clock edge.
- pc at 0x3FFC:
  - Next pc = 0x4000 and im_addr = 0x000.
